// File: rtl/parallel_adder.sv
// Registered WIDTH-bit adder: {Cout,Sum} = A + B + Cin with signed overflow flag.
// Carries come from 4-bit lookahead groups whose group carries ripple; one-cycle latency.
module parallel_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid
);

  localparam int unsigned GROUP   = 4;
  localparam int unsigned NGROUPS = WIDTH / GROUP;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [GROUP-1:0] gg;
  logic [GROUP-1:0] pp;
  logic             ci;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  assign g = A & B;
  assign p = A ^ B;

  // Lookahead inside each group from that group's carry-in; group carry-out feeds the next group.
  always_comb begin
    c  = '0;
    gg = '0;
    pp = '0;
    ci = 1'b0;
    c[0] = Cin;
    for (int unsigned k = 0; k < NGROUPS; k++) begin
      gg = g[k*GROUP +: GROUP];
      pp = p[k*GROUP +: GROUP];
      ci = c[k*GROUP];
      c[k*GROUP + 1] = gg[0] | (pp[0] & ci);
      c[k*GROUP + 2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
      c[k*GROUP + 3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                     | (pp[2] & pp[1] & pp[0] & ci);
      c[k*GROUP + 4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                     | (pp[3] & pp[2] & pp[1] & gg[0])
                     | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
    end
  end

  assign sum_c  = p ^ c[WIDTH-1:0];
  assign cout_c = c[WIDTH];
  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovf_c  = c[WIDTH] ^ c[WIDTH-1];

  // Result registers hold their value while idle; out_valid pulses per accepted operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= sum_c;
        Cout <= cout_c;
        Ovf  <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_parallel_adder.sv
// Self-checking bench for parallel_adder: directed boundary cases then random traffic
// against an integer-arithmetic reference model with one-cycle alignment.
module tb_parallel_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             in_valid;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
  logic             out_valid;

  int n_checks = 0;
  int n_fails  = 0;

  logic [WIDTH-1:0] m_sum  = '0;
  logic             m_cout = 1'b0;
  logic             m_ovf  = 1'b0;
  logic             m_ov   = 1'b0;

  parallel_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .in_valid (in_valid),
    .Sum      (Sum),
    .Cout     (Cout),
    .Ovf      (Ovf),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference: plain integer sums, signed overflow judged by range of the true signed result.
  task automatic model(input logic r, input logic iv, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic ci);
    int unsigned us;
    int          ss;
    if (r) begin
      m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_ov = 1'b0;
    end else if (iv) begin
      us = int'(a) + int'(b) + int'(ci);
      ss = int'($signed(a)) + int'($signed(b)) + int'(ci);
      m_sum  = us[WIDTH-1:0];
      m_cout = (us >= (1 << WIDTH));
      m_ovf  = (ss > 127) || (ss < -128);
      m_ov   = 1'b1;
    end else begin
      m_ov = 1'b0;
    end
  endtask

  task automatic check(input string tag);
    n_checks++;
    assert (Sum === m_sum) else begin
      n_fails++;
      $error("FAIL %s sum got %h exp %h", tag, Sum, m_sum);
    end
    n_checks++;
    assert (Cout === m_cout) else begin
      n_fails++;
      $error("FAIL %s cout got %b exp %b", tag, Cout, m_cout);
    end
    n_checks++;
    assert (Ovf === m_ovf) else begin
      n_fails++;
      $error("FAIL %s ovf got %b exp %b", tag, Ovf, m_ovf);
    end
    n_checks++;
    assert (out_valid === m_ov) else begin
      n_fails++;
      $error("FAIL %s out_valid got %b exp %b", tag, out_valid, m_ov);
    end
  endtask

  // Apply one cycle of inputs, advance past the edge, then compare.
  task automatic step(input string tag, input logic r, input logic iv,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
    rst = r; in_valid = iv; A = a; B = b; Cin = ci;
    @(posedge clk);
    #1;
    model(r, iv, a, b, ci);
    check(tag);
  endtask

  // Literal expectation straight from the boundary table, independent of the model.
  task automatic lit(input string tag, input logic [WIDTH-1:0] s, input logic co, input logic ov);
    n_checks++;
    assert ({Sum, Cout, Ovf, out_valid} === {s, co, ov, 1'b1}) else begin
      n_fails++;
      $error("FAIL %s got %h/%b/%b/%b exp %h/%b/%b/1", tag, Sum, Cout, Ovf, out_valid, s, co, ov);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;
    #1;

    step("reset0", 1'b1, 1'b1, 8'h55, 8'h55, 1'b0);
    lit_zero("reset0_lit");
    step("reset1", 1'b1, 1'b1, 8'h55, 8'h55, 1'b0);
    lit_zero("reset1_lit");

    step("basic", 1'b0, 1'b1, 8'h12, 8'h34, 1'b0);  lit("basic_lit", 8'h46, 1'b0, 1'b0);
    step("wrap", 1'b0, 1'b1, 8'hFF, 8'h01, 1'b0);   lit("wrap_lit", 8'h00, 1'b1, 1'b0);
    step("allones", 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1); lit("allones_lit", 8'hFF, 1'b1, 1'b0);
    step("xgroup", 1'b0, 1'b1, 8'h0F, 8'h00, 1'b1); lit("xgroup_lit", 8'h10, 1'b0, 1'b0);
    step("ovf_pos", 1'b0, 1'b1, 8'h7F, 8'h01, 1'b0); lit("ovf_pos_lit", 8'h80, 1'b0, 1'b1);
    step("ovf_neg", 1'b0, 1'b1, 8'h80, 8'h80, 1'b0); lit("ovf_neg_lit", 8'h00, 1'b1, 1'b1);

    step("idle0", 1'b0, 1'b0, 8'h11, 8'h22, 1'b1);
    step("idle1", 1'b0, 1'b0, 8'h33, 8'h44, 1'b0);
    step("b2b0", 1'b0, 1'b1, 8'h01, 8'h02, 1'b0);
    step("b2b1", 1'b0, 1'b1, 8'hA0, 8'h0B, 1'b1);
    step("midrst", 1'b1, 1'b1, 8'hF0, 8'hF0, 1'b1);
    lit_zero("midrst_lit");
    step("resume", 1'b0, 1'b1, 8'h40, 8'h40, 1'b0); lit("resume_lit", 8'h80, 1'b0, 1'b1);

    for (int i = 0; i < 12000; i++) begin
      step("rand",
           ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 7) != 0),
           WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  task automatic lit_zero(input string tag);
    n_checks++;
    assert ({Sum, Cout, Ovf, out_valid} === {8'h00, 3'b000}) else begin
      n_fails++;
      $error("FAIL %s got %h/%b/%b/%b exp 00/0/0/0", tag, Sum, Cout, Ovf, out_valid);
    end
  endtask

endmodule
